lsu_sequencer: RTL and testbench



---
 rtl/lsu_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_lsu_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_sequencer.sv
// Load/store sequencer: one CPU request per handshake, word-aligned
// memory strobes, fixed read latency, aligned and extended load data.
module lsu_sequencer #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] LAT = 3'(READ_LATENCY);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    ERR
  } state_t;

  state_t state, state_n;

  logic        we_q, we_n;
  logic [2:0]  f3_q, f3_n;
  logic [1:0]  off_q, off_n;
  logic [2:0]  cnt_q, cnt_n;

  logic        resp_valid_n;
  logic [31:0] resp_rdata_n;
  logic        resp_err_n;
  logic [31:0] mem_addr_n;
  logic [31:0] mem_wdata_n;
  logic [3:0]  mem_we_n;
  logic        mem_re_n;

  logic        illegal;
  logic        misaligned;
  logic [3:0]  lanes;
  logic [31:0] rep_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign req_ready = (state == IDLE);

  // Request decode, evaluated on the accepting cycle only
  always_comb begin
    illegal = (req_funct3 == 3'b011)
           || (req_funct3 == 3'b110)
           || (req_funct3 == 3'b111)
           || (req_we && req_funct3[2]);
    misaligned = 1'b0;
    lanes = 4'b1111;
    rep_wdata = req_wdata;
    unique case (1'b1)
      (req_funct3[1:0] == 2'b00): begin
        lanes = 4'b0001 << req_addr[1:0];
        rep_wdata = {4{req_wdata[7:0]}};
      end
      (req_funct3[1:0] == 2'b01): begin
        misaligned = req_addr[0];
        lanes = 4'b0011 << req_addr[1:0];
        rep_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        misaligned = (req_addr[1:0] != 2'b00);
      end
    endcase
  end

  always_comb begin
    ld_byte = mem_rdata[7:0];
    unique case (off_q)
      2'd0: ld_byte = mem_rdata[7:0];
      2'd1: ld_byte = mem_rdata[15:8];
      2'd2: ld_byte = mem_rdata[23:16];
      2'd3: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_data = mem_rdata;
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = 32'd0;
    endcase
  end

  always_comb begin
    state_n      = state;
    we_n         = we_q;
    f3_n         = f3_q;
    off_n        = off_q;
    cnt_n        = cnt_q;
    resp_valid_n = 1'b0;
    resp_rdata_n = resp_rdata;
    resp_err_n   = resp_err;
    mem_addr_n   = mem_addr;
    mem_wdata_n  = mem_wdata;
    mem_we_n     = 4'd0;
    mem_re_n     = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          we_n  = req_we;
          f3_n  = req_funct3;
          off_n = req_addr[1:0];
          if (illegal || misaligned) begin
            state_n      = ERR;
            resp_valid_n = 1'b1;
            resp_err_n   = 1'b1;
            resp_rdata_n = 32'd0;
          end else begin
            state_n    = ACCESS;
            mem_addr_n = {req_addr[31:2], 2'b00};
            if (req_we) begin
              mem_we_n    = lanes;
              mem_wdata_n = rep_wdata;
            end else begin
              mem_re_n = 1'b1;
              cnt_n    = LAT;
            end
          end
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_n      = IDLE;
          resp_valid_n = 1'b1;
          resp_err_n   = 1'b0;
          resp_rdata_n = 32'd0;
        end else begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        cnt_n = cnt_q - 3'd1;
        // Read data is valid while the counter sits at one
        if (cnt_q == 3'd1) begin
          state_n      = IDLE;
          resp_valid_n = 1'b1;
          resp_err_n   = 1'b0;
          resp_rdata_n = ld_data;
        end
      end
      ERR: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      f3_q       <= 3'd0;
      off_q      <= 2'd0;
      cnt_q      <= 3'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      mem_we     <= 4'd0;
      mem_re     <= 1'b0;
    end else begin
      state      <= state_n;
      we_q       <= we_n;
      f3_q       <= f3_n;
      off_q      <= off_n;
      cnt_q      <= cnt_n;
      resp_valid <= resp_valid_n;
      resp_rdata <= resp_rdata_n;
      resp_err   <= resp_err_n;
      mem_addr   <= mem_addr_n;
      mem_wdata  <= mem_wdata_n;
      mem_we     <= mem_we_n;
      mem_re     <= mem_re_n;
    end
  end

endmodule

// File: tb/tb_lsu_sequencer.sv
// Directed bench for lsu_sequencer: one instance at READ_LATENCY=1,
// one at READ_LATENCY=3, each with its own latency-accurate memory.
module tb_lsu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we [2];
  logic [2:0]  req_funct3 [2];
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_wdata [2];
  logic [3:0]  mem_we [2];
  logic        mem_re [2];
  logic [31:0] mem_rdata [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lsu_sequencer #(.READ_LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_funct3(req_funct3[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_we(mem_we[0]),
    .mem_re(mem_re[0]), .mem_rdata(mem_rdata[0])
  );

  lsu_sequencer #(.READ_LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_funct3(req_funct3[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_we(mem_we[1]),
    .mem_re(mem_re[1]), .mem_rdata(mem_rdata[1])
  );

  function automatic logic [31:0] rd(input logic [31:0] a);
    return (a == 32'h200) ? 32'h80FF7F01 : 32'h0;
  endfunction

  // Read pipeline: data appears exactly N cycles after mem_re
  logic        v_pipe [2][8];
  logic [31:0] a_pipe [2][8];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      v_pipe[i][0] <= mem_re[i];
      a_pipe[i][0] <= mem_addr[i];
      for (int k = 1; k < 8; k++) begin
        v_pipe[i][k] <= v_pipe[i][k-1];
        a_pipe[i][k] <= a_pipe[i][k-1];
      end
    end
  end

  assign mem_rdata[0] = v_pipe[0][0] ? rd(a_pipe[0][0]) : 32'hBAD0BAD0;
  assign mem_rdata[1] = v_pipe[1][2] ? rd(a_pipe[1][2]) : 32'hBAD0BAD0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req_tx(input int i, input logic we,
                        input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic exp_err,
                        input logic [31:0] exp_rd, input logic [3:0] exp_we,
                        input logic [31:0] exp_wd, input int exp_lat);
    int cyc, n_re, n_we, both;
    @(negedge clk);
    chk("ready_c0", 32'(req_ready[i]), 32'd1);
    req_valid[i]  = 1'b1;
    req_we[i]     = we;
    req_funct3[i] = f3;
    req_addr[i]   = addr;
    req_wdata[i]  = wdata;
    @(negedge clk);
    req_valid[i] = 1'b0;
    if (!exp_err) begin
      chk("mem_addr_c1", mem_addr[i], {addr[31:2], 2'b00});
      chk("mem_we_c1", 32'(mem_we[i]), 32'(exp_we));
      chk("mem_re_c1", 32'(mem_re[i]), 32'(!we));
      if (we) chk("mem_wdata_c1", mem_wdata[i], exp_wd);
    end
    cyc = 1; n_re = 0; n_we = 0; both = 0;
    forever begin
      if (mem_re[i]) n_re++;
      if (mem_we[i] != 4'd0) n_we++;
      if (mem_re[i] && mem_we[i] != 4'd0) both++;
      if (resp_valid[i] || cyc >= 20) break;
      @(negedge clk);
      cyc++;
    end
    chk("resp_cycle", 32'(cyc), 32'(exp_lat));
    chk("resp_err", 32'(resp_err[i]), 32'(exp_err));
    chk("resp_rdata", resp_rdata[i], exp_rd);
    chk("re_pulses", 32'(n_re), 32'((!exp_err && !we) ? 1 : 0));
    chk("we_pulses", 32'(n_we), 32'((!exp_err && we) ? 1 : 0));
    chk("re_we_overlap", 32'(both), 32'd0);
    @(negedge clk);
    chk("resp_one_cycle", 32'(resp_valid[i]), 32'd0);
  endtask

  initial begin
    int busy_bad, pulses;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_we[i] = 1'b0; req_funct3[i] = 3'd0;
      req_addr[i] = 32'd0; req_wdata[i] = 32'd0;
    end
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready[0]), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid[0]), 32'd0);
    chk("rst_resp_rdata", resp_rdata[0], 32'd0);
    chk("rst_resp_err", 32'(resp_err[0]), 32'd0);
    chk("rst_mem_addr", mem_addr[0], 32'd0);
    chk("rst_mem_wdata", mem_wdata[0], 32'd0);
    chk("rst_mem_we", 32'(mem_we[0]), 32'd0);
    chk("rst_mem_re", 32'(mem_re[0]), 32'd0);
    chk("rst_ready_l3", 32'(req_ready[1]), 32'd1);

    // stores
    req_tx(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 4'b1111, 32'hDEADBEEF, 2);
    req_tx(0, 1, 3'b000, 32'h103, 32'h000000A5, 0, 0, 4'b1000, 32'hA5A5A5A5, 2);
    req_tx(0, 1, 3'b001, 32'h102, 32'h00001234, 0, 0, 4'b1100, 32'h12341234, 2);
    req_tx(0, 1, 3'b000, 32'h101, 32'h0000003C, 0, 0, 4'b0010, 32'h3C3C3C3C, 2);

    // loads, latency 1 and 3
    for (int i = 0; i < 2; i++) begin
      int lat;
      lat = (i == 0) ? 3 : 5;
      req_tx(i, 0, 3'b000, 32'h203, 0, 0, 32'hFFFFFF80, 0, 0, lat);
      req_tx(i, 0, 3'b100, 32'h203, 0, 0, 32'h00000080, 0, 0, lat);
      req_tx(i, 0, 3'b001, 32'h200, 0, 0, 32'h00007F01, 0, 0, lat);
      req_tx(i, 0, 3'b101, 32'h202, 0, 0, 32'h000080FF, 0, 0, lat);
      req_tx(i, 0, 3'b010, 32'h200, 0, 0, 32'h80FF7F01, 0, 0, lat);
      req_tx(i, 0, 3'b000, 32'h201, 0, 0, 32'h0000007F, 0, 0, lat);
      req_tx(i, 0, 3'b001, 32'h202, 0, 0, 32'hFFFF80FF, 0, 0, lat);
    end

    // errors: misaligned and illegal funct3
    req_tx(0, 0, 3'b010, 32'h101, 0, 1, 0, 0, 0, 1);
    req_tx(0, 0, 3'b001, 32'h201, 0, 1, 0, 0, 0, 1);
    req_tx(0, 0, 3'b011, 32'h200, 0, 1, 0, 0, 0, 1);
    req_tx(1, 1, 3'b100, 32'h100, 32'h11, 1, 0, 0, 0, 1);
    req_tx(1, 1, 3'b010, 32'h102, 32'h11, 1, 0, 0, 0, 1);
    req_tx(1, 0, 3'b110, 32'h200, 0, 1, 0, 0, 0, 1);

    // back-to-back SW then LW on the latency-3 instance
    @(negedge clk);
    chk("b2b_ready_c0", 32'(req_ready[1]), 32'd1);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_funct3[1] = 3'b010;
    req_addr[1] = 32'h100; req_wdata[1] = 32'hCAFEF00D;
    @(negedge clk);
    chk("b2b_st_we", 32'(mem_we[1]), 32'hF);
    chk("b2b_ready_c1", 32'(req_ready[1]), 32'd0);
    req_we[1] = 1'b0; req_addr[1] = 32'h200; req_wdata[1] = 32'd0;
    @(negedge clk);
    chk("b2b_st_resp", 32'(resp_valid[1]), 32'd1);
    chk("b2b_ready_resp", 32'(req_ready[1]), 32'd1);
    @(negedge clk);
    req_valid[1] = 1'b0;
    chk("b2b_ld_re", 32'(mem_re[1]), 32'd1);
    busy_bad = 0;
    for (int k = 0; k < 4; k++) begin
      if (req_ready[1] !== 1'b0) busy_bad++;
      @(negedge clk);
    end
    chk("b2b_busy", 32'(busy_bad), 32'd0);
    chk("b2b_ld_resp", 32'(resp_valid[1]), 32'd1);
    chk("b2b_ld_data", resp_rdata[1], 32'h80FF7F01);

    // reset during WAIT of an LW
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_funct3[1] = 3'b010;
    req_addr[1] = 32'h200;
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_ready", 32'(req_ready[1]), 32'd1);
    chk("rst_mid_re", 32'(mem_re[1]), 32'd0);
    chk("rst_mid_resp", 32'(resp_valid[1]), 32'd0);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (resp_valid[1] !== 1'b0) pulses++;
    end
    chk("rst_mid_no_resp", 32'(pulses), 32'd0);
    req_tx(1, 0, 3'b100, 32'h202, 0, 0, 32'h000000FF, 0, 0, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
